// File: rtl/fifo_read_drain.sv
// fifo_read_drain
//   Drains a FIFO read port into a valid/ready stream. One read per cycle,
//   read data arrives one rd_clk later and lands in a 2-entry skid buffer, so
//   back-pressure never loses a word that is already in flight.
//
//   Optional feature: define FIFO_READ_DRAIN_CNT_EN to count delivered words
//   on rd_count (wraps modulo 2^CNT_WIDTH). Without it rd_count is tied to 0.
//
// Ports
//   rd_clk, reset          clock, async active-high reset
//   enable                 high = keep reading, low = stop reads and flush
//   fifo_empty             FIFO empty flag (gates rd_en)
//   fifo_almost_empty      registered onto low_water
//   data_out [DATA_WIDTH]  FIFO read data, valid one cycle after rd_en
//   rd_en                  FIFO read strobe (combinational)
//   m_valid/m_data/m_ready downstream stream
//   busy                   not IDLE, or words buffered / in flight
//   low_water              fifo_almost_empty delayed one cycle
//   rd_count [CNT_WIDTH]   delivered word count
module fifo_read_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  low_water,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;   // oldest word
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  low_water_q;
  logic                  pop;
  logic [2:0]            committed;

  assign pop       = (occ_q != 2'd0) && m_ready;
  // Words that will occupy the buffer after this edge, before any new read.
  assign committed = {1'b0, occ_q} + {2'b00, pend_q};
  assign rd_en     = (state_q == RUN) && !fifo_empty &&
                     (committed < (3'd2 + {2'b00, pop}));

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf0_q;
  assign busy      = (state_q != IDLE) || (occ_q != 2'd0) || pend_q;
  assign low_water = low_water_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = FLUSH;
      FLUSH: begin
        if (enable)                                state_d = RUN;
        else if ((occ_q == 2'd0) && !pend_q)       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer: capture of the in-flight word and pop can share an edge.
  always_comb begin
    pend_d = rd_en;
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({pend_q, pop})
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = data_out;
        else               buf1_d = data_out;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = data_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      occ_q       <= 2'd0;
      pend_q      <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      low_water_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      low_water_q <= fifo_almost_empty;
    end
  end

`ifdef FIFO_READ_DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign cnt_d    = cnt_q + CNT_WIDTH'(pop);
  assign rd_count = cnt_q;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_drain.sv
// tb_fifo_read_drain
//   Randomized and directed stimulus against a queue-based model: a source
//   FIFO array feeds the DUT, every word the DUT reads is pushed on an
//   expected queue, and the monitor pops it when the stream hands a word out.
//   Directed observations are queued by the stimulus and compared by the
//   monitor, which owns the pass/fail counters.
module tb_fifo_read_drain;
  localparam int DW = 32;
  localparam int CW = 8;   // small counter so random traffic wraps it
`ifdef FIFO_READ_DRAIN_CNT_EN
  localparam longint CNT4 = 4;
`else
  localparam longint CNT4 = 0;
`endif

  logic          rd_clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic          fifo_almost_empty = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          rd_en, m_valid, m_ready = 1'b0, busy, low_water;
  logic [DW-1:0] m_data;
  logic [CW-1:0] rd_count;

  fifo_read_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk(rd_clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_almost_empty(fifo_almost_empty), .data_out(data_out), .rd_en(rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy),
    .low_water(low_water), .rd_count(rd_count)
  );

  always #5 rd_clk = ~rd_clk;

  // Source FIFO model: data appears one cycle after the read is sampled.
  logic [DW-1:0] mem [0:16383];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic [DW-1:0] exp_q [$];

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (!reset && rd_en && !fifo_empty) begin
      data_out <= mem[rd_ptr];
      exp_q.push_back(mem[rd_ptr]);
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Directed observations handed from stimulus to monitor.
  string  rq_name [$];
  longint rq_act  [$];
  longint rq_exp  [$];

  // Monitor / scoreboard
  int            n_tests = 0;
  int            n_fail  = 0;
  int            exp_rd  = 0;
  int            req_rd  = 0;
  logic [CW-1:0] cnt_m   = '0;
  logic          stall_p = 1'b0;
  logic [DW-1:0] data_p  = '0;
  logic          ae_p    = 1'b0;
  logic          ae_vld  = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge rd_clk) begin
    while (req_rd < rq_name.size()) begin
      chk(rq_name[req_rd], rq_act[req_rd], rq_exp[req_rd]);
      req_rd++;
    end
    if (reset) begin
      exp_rd  = exp_q.size();   // buffered and in-flight words are discarded
      cnt_m   = '0;
      stall_p = 1'b0;
      ae_vld  = 1'b0;
    end else begin
      chk("rd_en_while_empty", longint'(rd_en && fifo_empty), 0);
      chk("rd_count", rd_count, cnt_m);
      if (ae_vld) chk("low_water", low_water, ae_p);
      if (stall_p) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, data_p);
      end
      if (exp_q.size() > exp_rd) chk("busy_outstanding", busy, 1);
      if (m_valid && m_ready) begin
        if (exp_rd < exp_q.size()) begin
          chk("pop_data", m_data, exp_q[exp_rd]);
          exp_rd++;
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: actual word %0h, required no word at %0t", m_data, $time);
        end
`ifdef FIFO_READ_DRAIN_CNT_EN
        cnt_m = cnt_m + 1'b1;
`endif
      end
      stall_p = m_valid && !m_ready;
      data_p  = m_data;
      ae_p    = fifo_almost_empty;
      ae_vld  = 1'b1;
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic post(input string n, input longint a, input longint e);
    rq_name.push_back(n);
    rq_act.push_back(a);
    rq_exp.push_back(e);
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  initial begin
    logic [DW-1:0] w [5];
    logic [7:0]    rd_pat;
    int            pulses;

    tick();
    tick();
    post("rst_m_valid", m_valid, 0);
    post("rst_rd_en", rd_en, 0);
    post("rst_busy", busy, 0);
    post("rst_rd_count", rd_count, 0);
    post("rst_low_water", low_water, 0);
    post("rst_m_data", m_data, 0);
    reset = 1'b0;
    tick();

    // Four words streamed back to back.
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      push(w[i]);
    end
    m_ready = 1'b1;
    enable  = 1'b1;
    rd_pat  = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      rd_pat[k-1] = rd_en;
      if (k == 2) post("first_valid_early", m_valid, 0);
      if (k == 3) post("first_valid", m_valid, 1);
      if (k >= 3 && k <= 6) post("stream_order", m_data, w[k-3]);
    end
    post("rd_en_pattern", rd_pat, 8'h0F);
    post("count_after_4", rd_count, CNT4);
    enable = 1'b0;
    repeat (4) tick();
    post("idle_after_stream", busy, 0);

    // Back-pressure: only two reads may be issued.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      push(w[i]);
    end
    enable = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      pulses += int'(rd_en);
      if (k >= 3) begin
        post("stall_valid", m_valid, 1);
        post("stall_data", m_data, w[0]);
      end
    end
    post("stall_pulses", pulses, 2);
    m_ready = 1'b1;
    repeat (12) tick();
    enable = 1'b0;
    repeat (4) tick();
    post("idle_after_stall", busy, 0);

    // Enabled on an empty FIFO.
    enable = 1'b1;
    repeat (5) begin
      tick();
      post("empty_rd_en", rd_en, 0);
      post("empty_m_valid", m_valid, 0);
      post("empty_busy", busy, 1);
    end
    enable = 1'b0;
    repeat (3) tick();

    // Enable drops while a read is being issued.
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      push(w[i]);
    end
    m_ready = 1'b1;
    enable  = 1'b1;
    tick();
    post("drop_rd_en_high", rd_en, 1);
    enable = 1'b0;
    tick();
    post("flush_no_read", rd_en, 0);
    tick();
    post("flush_valid", m_valid, 1);
    post("flush_data", m_data, w[0]);
    tick();
    tick();
    post("flush_idle", busy, 0);
    repeat (4) begin
      tick();
      post("idle_no_read", rd_en, 0);
    end

    // Reset with a buffered word and a read in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push($urandom);
    enable = 1'b1;
    repeat (3) tick();
    post("pre_rst_valid", m_valid, 1);
    post("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    post("mid_rst_m_valid", m_valid, 0);
    post("mid_rst_rd_en", rd_en, 0);
    post("mid_rst_rd_count", rd_count, 0);
    post("mid_rst_busy", busy, 0);
    enable = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    m_ready = 1'b1;
    repeat (4) begin
      tick();
      post("no_valid_after_rst", m_valid, 0);
    end

    // Random traffic.
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 1) == 1) push($urandom);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      m_ready           = ($urandom_range(0, 9) < 7);
      fifo_almost_empty = $urandom_range(0, 1) == 1;
    end

    // Drain everything and return to IDLE.
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10000 && !fifo_empty; i++) tick();
    post("drain_empty", fifo_empty, 1);
    enable = 1'b0;
    for (int i = 0; i < 20 && busy; i++) tick();
    post("drain_idle", busy, 0);
    tick();
    post("outstanding_words", longint'(exp_q.size() - exp_rd), 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
